// File: rtl/sad_search_ctrl.sv
// Motion-search sequencer: issues one SAD job per candidate block, keeps the
// running minimum SAD and its index, and aborts if the engine stops answering.
module sad_search_ctrl #(
  parameter int NUM_CAND = 16,
  parameter int IDX_W    = 4,
  parameter int SAD_W    = 32,
  parameter int TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sad_done,
  input  logic [SAD_W-1:0] sad_value,
  output logic             sad_go,
  output logic [IDX_W-1:0] cand_idx,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CAND - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CMP, FIN} state_e;

  state_e           state_q;
  logic [TMR_W-1:0] timer_q;
  logic [SAD_W-1:0] cap_q;
  logic [SAD_W-1:0] best_sad_q;
  logic [IDX_W-1:0] best_idx_q;
  logic [IDX_W-1:0] cand_q;
  logic             busy_q;
  logic             terr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      cap_q      <= '0;
      best_sad_q <= '1;
      best_idx_q <= '0;
      cand_q     <= '0;
      busy_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          cand_q     <= '0;
          best_sad_q <= '1;
          best_idx_q <= '0;
          terr_q     <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= ISSUE;
        end
        ISSUE: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        // A result landing on the last watchdog cycle still counts.
        WAIT: if (sad_done) begin
          cap_q   <= sad_value;
          state_q <= CMP;
        end else if (timer_q == TMR_LAST) begin
          terr_q  <= 1'b1;
          state_q <= FIN;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
        CMP: begin
          if (cap_q < best_sad_q) begin
            best_sad_q <= cap_q;
            best_idx_q <= cand_q;
          end
          if (cand_q == IDX_LAST) begin
            state_q <= FIN;
          end else begin
            cand_q  <= cand_q + 1'b1;
            state_q <= ISSUE;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pulses are decoded from the state register so async reset drops them at once.
  assign sad_go      = (state_q == ISSUE);
  assign done        = (state_q == FIN);
  assign cand_idx    = cand_q;
  assign best_sad    = best_sad_q;
  assign best_idx    = best_idx_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl: behavioural SAD engine, vector table of searches,
// scoreboard of expected go indices and search results.
module tb_sad_search_ctrl;
  localparam int NC = 4;
  localparam int TO = 16;

  logic        clk, rst, start, sad_done;
  logic [31:0] sad_value;
  logic        sad_go, busy, done, timeout_err;
  logic [3:0]  cand_idx, best_idx;
  logic [31:0] best_sad;

  sad_search_ctrl #(.NUM_CAND(NC), .IDX_W(4), .SAD_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .sad_done(sad_done), .sad_value(sad_value),
    .sad_go(sad_go), .cand_idx(cand_idx), .best_sad(best_sad), .best_idx(best_idx),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [NC-1:0][7:0]  lat;   // engine latency per candidate, 0 = never answers
    logic [NC-1:0][31:0] val;
    logic                stray;
    logic                hold;
    logic [31:0]         e_sad;
    logic [3:0]          e_idx;
    logic                e_to;
    logic [7:0]          e_ngo;
  } vec_t;

  typedef struct packed {
    logic [31:0] s;
    logic [3:0]  i;
    logic        t;
  } res_t;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int n_go, n_done, first_go_cyc, last_go_cyc, done_cyc;
  int eng_cnt, eng_idx;
  vec_t cur_v;
  logic [3:0] idx_q[$];
  res_t res_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input int l0, l1, l2, l3,
                              input logic [31:0] v0, v1, v2, v3,
                              input bit st, hd, input logic [31:0] es,
                              input int ei, input bit et, input int en);
    vec_t v;
    v.lat[0] = 8'(l0); v.lat[1] = 8'(l1); v.lat[2] = 8'(l2); v.lat[3] = 8'(l3);
    v.val[0] = v0; v.val[1] = v1; v.val[2] = v2; v.val[3] = v3;
    v.stray = st; v.hold = hd; v.e_sad = es; v.e_idx = 4'(ei); v.e_to = et; v.e_ngo = 8'(en);
    return v;
  endfunction

  // Behavioural SAD engine: answers lat cycles after the go pulse.
  initial begin
    sad_done = 1'b0; sad_value = '0; eng_cnt = -1; eng_idx = 0;
    forever begin
      @(negedge clk);
      sad_done = 1'b0;
      if (!rst) eng_cnt = -1;
      else if (sad_go) begin
        eng_idx = int'(cand_idx) % NC;
        eng_cnt = (cur_v.lat[eng_idx] == 0) ? -1 : int'(cur_v.lat[eng_idx]);
        if (cur_v.stray) begin sad_done = 1'b1; sad_value = 32'd1; end
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          sad_done = 1'b1; sad_value = cur_v.val[eng_idx]; eng_cnt = -1;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if (rst && sad_go) begin
      n_go++; last_go_cyc = cyc;
      if (first_go_cyc < 0) first_go_cyc = cyc;
      if (idx_q.size() == 0) chk("unexpected_sad_go", 64'(cand_idx), 64'hDEAD);
      else chk("go_cand_idx", 64'(cand_idx), 64'(idx_q.pop_front()));
    end
    if (rst && done) begin
      res_t r;
      n_done++; done_cyc = cyc;
      if (res_q.size() == 0) chk("unexpected_done", 64'(done), 64'h0);
      else begin
        r = res_q.pop_front();
        chk("best_sad", 64'(best_sad), 64'(r.s));
        chk("best_idx", 64'(best_idx), 64'(r.i));
        chk("timeout_err", 64'(timeout_err), 64'(r.t));
      end
    end
  end

  task automatic clr_counts();
    n_go = 0; n_done = 0; first_go_cyc = -1; last_go_cyc = -1; done_cyc = -1;
  endtask

  task automatic run_search(input vec_t v, input string tag);
    int sc;
    bit got;
    res_t r;
    cur_v = v;
    clr_counts();
    for (int i = 0; i < int'(v.e_ngo); i++) idx_q.push_back(4'(i));
    r.s = v.e_sad; r.i = v.e_idx; r.t = v.e_to;
    res_q.push_back(r);
    @(negedge clk); start = 1'b1; sc = cyc;
    @(negedge clk); if (!v.hold) start = 1'b0;
    chk({tag, "_busy_after_start"}, 64'(busy), 64'h1);
    chk({tag, "_terr_cleared"}, 64'(timeout_err), 64'h0);
    got = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    if (!got) chk({tag, "_done_timeout"}, 64'h0, 64'h1);
    @(negedge clk);
    start = 1'b0;  // start stayed high through the FIN edge when held
    chk({tag, "_busy_low_after_done"}, 64'(busy), 64'h0);
    repeat (20) @(negedge clk);
    chk({tag, "_go_count"}, 64'(n_go), 64'(v.e_ngo));
    chk({tag, "_done_count"}, 64'(n_done), 64'h1);
    chk({tag, "_first_go_latency"}, 64'(first_go_cyc - sc), 64'h1);
    if (v.e_to) chk({tag, "_wd_done_latency"}, 64'(done_cyc - last_go_cyc), 64'(TO + 1));
    else chk({tag, "_done_latency"}, 64'(done_cyc - last_go_cyc),
             64'(int'(v.lat[int'(v.e_ngo) - 1]) + 2));
    chk({tag, "_sb_empty"}, 64'(idx_q.size() + res_q.size()), 64'h0);
    idx_q.delete(); res_q.delete();
  endtask

  vec_t tbl[7];
  vec_t basic;

  initial begin
    basic  = mk(10, 10, 10, 10, 500, 120, 300, 120, 0, 0, 120, 1, 0, 4);
    tbl[0] = basic;
    tbl[1] = mk(10, 10, 10, 10, 500, 120, 300, 120, 1, 1, 120, 1, 0, 4);  // stray done + held start
    tbl[2] = mk(10, 10,  0, 10, 500, 120, 300, 120, 0, 0, 120, 1, 1, 3);  // watchdog on cand 2
    tbl[3] = mk(10, 16, 10, 10, 500, 120, 300, 120, 0, 0, 120, 1, 0, 4);  // done on last timer cycle
    tbl[4] = mk( 3,  3,  3,  3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                0, 0, 32'hFFFF_FFFF, 0, 0, 4);
    tbl[5] = mk( 1,  2,  5,  1, 40, 30, 20, 10, 0, 0, 10, 3, 0, 4);
    tbl[6] = mk( 7,  4,  9,  2, 0, 5, 0, 7, 0, 0, 0, 0, 0, 4);

    cur_v = basic;
    clr_counts();
    start = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_sad_go_count", 64'(n_go), 64'h0);
    chk("idle_done_count", 64'(n_done), 64'h0);
    chk("idle_busy", 64'(busy), 64'h0);
    chk("idle_best_sad", 64'(best_sad), 64'hFFFF_FFFF);
    chk("idle_best_idx", 64'(best_idx), 64'h0);
    chk("idle_terr", 64'(timeout_err), 64'h0);

    for (int i = 0; i < 7; i++) run_search(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of candidate 2's wait.
    begin
      int g;
      cur_v = basic;
      clr_counts();
      for (int i = 0; i < 3; i++) idx_q.push_back(4'(i));
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      g = (sad_go) ? 1 : 0;
      for (int i = 0; i < 200 && g < 3; i++) begin
        @(negedge clk);
        if (sad_go) g++;
      end
      chk("rstmid_reached_cand2", 64'(g), 64'h3);
      repeat (3) @(negedge clk);
      chk("rstmid_busy_before", 64'(busy), 64'h1);
      #2 rst = 1'b0;
      #1;
      chk("rstmid_sad_go", 64'(sad_go), 64'h0);
      chk("rstmid_busy", 64'(busy), 64'h0);
      chk("rstmid_done", 64'(done), 64'h0);
      chk("rstmid_cand_idx", 64'(cand_idx), 64'h0);
      chk("rstmid_best_sad", 64'(best_sad), 64'hFFFF_FFFF);
      chk("rstmid_best_idx", 64'(best_idx), 64'h0);
      chk("rstmid_terr", 64'(timeout_err), 64'h0);
      chk("rstmid_sb_empty", 64'(idx_q.size()), 64'h0);
      idx_q.delete(); res_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_search(basic, "after_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
